// File: rtl/digit_capture.sv
// Purpose: threshold + OR-pool a raster grayscale canvas (28*SCALE square) into a 28x28 bitmap, run the NN handshake.
// Latency: nn_start one cycle after the last pixel; result/result_valid one cycle after nn_resp is seen in WAIT.
// Backpressure: pix_ready is high only in CAPTURE; pixels offered in START/WAIT/NNRST stay with upstream.
//
// Ports:
//   Clk, Rst                           clock, synchronous active-high reset
//   pix_valid/pix_sof/pix_data/pix_ready  pixel stream in (sof marks a frame's first pixel)
//   nn_data[783:0]                     bitmap, bit = cell_row*28 + cell_col
//   nn_start, nn_resp, nn_prediction, nn_rst  network handshake
//   result, result_valid, busy         latched prediction, update pulse, network-in-flight flag
module digit_capture #(
  parameter int SCALE  = 10,
  parameter int PIX_W  = 8,
  parameter int THRESH = 128
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             pix_valid,
  input  logic             pix_sof,
  input  logic [PIX_W-1:0] pix_data,
  output logic             pix_ready,
  output logic [783:0]     nn_data,
  output logic             nn_start,
  input  logic             nn_resp,
  input  logic [4:0]       nn_prediction,
  output logic             nn_rst,
  output logic [4:0]       result,
  output logic             result_valid,
  output logic             busy
);

  typedef enum logic [1:0] {S_CAPTURE, S_START, S_WAIT, S_NNRST} state_e;

  localparam logic [3:0]       SUB_LAST  = 4'(SCALE - 1);
  localparam logic [4:0]       CELL_LAST = 5'd27;
  localparam logic [PIX_W-1:0] THR       = PIX_W'(THRESH);

  state_e       state_q, state_d;
  logic [3:0]   sx_q, sx_d, sy_q, sy_d;
  logic [4:0]   cx_q, cx_d, cy_q, cy_d;
  logic [783:0] bitmap_q, bitmap_d;
  logic [4:0]   result_q, result_d;
  logic         result_valid_q, result_valid_d;

  logic       xfer, ink, frame_start, last_pix;
  logic [3:0] pos_sx, pos_sy;
  logic [4:0] pos_cx, pos_cy;
  logic       sx_wrap, cx_wrap, sy_wrap, cy_wrap;
  logic [9:0] cell_idx;

  assign xfer = pix_valid & pix_ready;
  assign ink  = (pix_data >= THR);

  // A transfer at the origin or with sof begins a frame; a mid-frame sof
  // snaps the position back to the origin so the partial frame is dropped.
  assign frame_start = xfer & (pix_sof | ((sx_q == 4'd0) & (sy_q == 4'd0) &
                                          (cx_q == 5'd0) & (cy_q == 5'd0)));

  // Position of the pixel being transferred this cycle.
  assign pos_sx = frame_start ? 4'd0 : sx_q;
  assign pos_sy = frame_start ? 4'd0 : sy_q;
  assign pos_cx = frame_start ? 5'd0 : cx_q;
  assign pos_cy = frame_start ? 5'd0 : cy_q;

  assign sx_wrap  = (pos_sx == SUB_LAST);
  assign cx_wrap  = (pos_cx == CELL_LAST);
  assign sy_wrap  = (pos_sy == SUB_LAST);
  assign cy_wrap  = (pos_cy == CELL_LAST);
  assign last_pix = xfer & sx_wrap & cx_wrap & sy_wrap & cy_wrap;
  assign cell_idx = 10'(pos_cy) * 10'd28 + 10'(pos_cx);

  // Nested raster counters: sx -> cx -> sy -> cy, each carrying on wrap.
  always_comb begin
    sx_d     = sx_q;
    cx_d     = cx_q;
    sy_d     = sy_q;
    cy_d     = cy_q;
    bitmap_d = frame_start ? '0 : bitmap_q;
    if (xfer) begin
      sx_d = sx_wrap ? 4'd0 : pos_sx + 4'd1;
      cx_d = sx_wrap ? (cx_wrap ? 5'd0 : pos_cx + 5'd1) : pos_cx;
      sy_d = (sx_wrap & cx_wrap) ? (sy_wrap ? 4'd0 : pos_sy + 4'd1) : pos_sy;
      cy_d = (sx_wrap & cx_wrap & sy_wrap) ? (cy_wrap ? 5'd0 : pos_cy + 5'd1) : pos_cy;
      if (ink) bitmap_d[cell_idx] = 1'b1;
    end
  end

  // Result capture: nn_resp only counts while waiting.
  always_comb begin
    result_d       = result_q;
    result_valid_d = 1'b0;
    if ((state_q == S_WAIT) && nn_resp) begin
      result_d       = nn_prediction;
      result_valid_d = 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q        <= S_CAPTURE;
      sx_q           <= 4'd0;
      sy_q           <= 4'd0;
      cx_q           <= 5'd0;
      cy_q           <= 5'd0;
      bitmap_q       <= '0;
      result_q       <= 5'd0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      sx_q           <= sx_d;
      sy_q           <= sy_d;
      cx_q           <= cx_d;
      cy_q           <= cy_d;
      bitmap_q       <= bitmap_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_CAPTURE: if (last_pix) state_d = S_START;
      S_START:   state_d = S_WAIT;
      S_WAIT:    if (nn_resp) state_d = S_NNRST;
      S_NNRST:   state_d = S_CAPTURE;
      default:   state_d = S_CAPTURE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    pix_ready = (state_q == S_CAPTURE) & ~Rst;
    nn_start  = (state_q == S_START);
    busy      = (state_q == S_START) | (state_q == S_WAIT);
    nn_rst    = Rst | (state_q == S_NNRST);
  end

  assign nn_data      = bitmap_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: doc/digit_capture.md
# digit_capture

Upstream front end of the digit classifier. Accepts a raster-ordered grayscale pixel stream of a square canvas, thresholds and OR-pools it down to the 28×28 binary image, and presents that image as the 784-bit `nn_data` vector. It then pulses `nn_start`, waits for `nn_resp`, latches the 5-bit prediction, and pulses `nn_rst` to return the network to Ready for the next frame.

## Interface

Parameters:
- `SCALE`, 10: canvas edge is 28×SCALE pixels. Each output cell ORs a SCALE×SCALE block. Legal range is 1..16.
- `PIX_W`, 8: pixel width.
- `THRESH`, 128: a pixel is ink when `pix_data >= THRESH` (unsigned).

Ports:
- `Clk` in 1: the single clock.
- `Rst` in 1: synchronous, active-high reset.
- `pix_valid` in 1: upstream pixel valid.
- `pix_sof` in 1: marks the first pixel of a frame. Qualified by `pix_valid`.
- `pix_data` in PIX_W: grayscale pixel.
- `pix_ready` out 1: block accepts a pixel this cycle.
- `nn_data` out 784: binary image. Bit index = cell_row×28 + cell_col.
- `nn_start` out 1: one-cycle start pulse to the network.
- `nn_resp` in 1: network result valid. A level, held until the network is reset.
- `nn_prediction` in 5: network argmax.
- `nn_rst` out 1: network reset.
- `result` out 5: last latched prediction.
- `result_valid` out 1: one-cycle pulse when `result` updates.
- `busy` out 1: high in START and WAIT.

## Operation

- FSM states: CAPTURE, START, WAIT, NNRST.
- Transfer occurs when `pix_valid & pix_ready`. `pix_ready` = (state==CAPTURE) & ~Rst, decoded combinationally from state.
- Position counters:
  - Sub-pixel `sx`, `sy` run 0..SCALE-1.
  - Cell `cx`, `cy` run 0..27.
  - `sx` advances every transfer. Wrap of `sx` increments `cx`; wrap of `cx` increments `sy`; wrap of `sy` increments `cy`.
  - No division is used.
- Ink write: on a transfer with ink, set bitmap bit `cy*28+cx`. Bits are never cleared mid-frame.
- Frame start: a transfer at position (0,0), or any transfer with `pix_sof`=1, starts a new frame.
  - The bitmap is replaced by all zeros except this pixel's ink bit at index 0.
  - Counters restart from (0,0), then advance.
  - `pix_sof` mid-frame therefore resynchronises: the partial frame is discarded.
- Last pixel: `cx=27, sx=SCALE-1, cy=27, sy=SCALE-1`. On its transfer, the final ink bit is written, counters wrap to 0, and the FSM goes to START.
- START: `nn_start`=1 for exactly one cycle, then WAIT.
- WAIT: hold until `nn_resp`=1. Then `result <= nn_prediction` and `result_valid <= 1` for one cycle, and the FSM goes to NNRST.
- NNRST: `nn_rst`=1 for one cycle, then CAPTURE.
- `nn_rst` = Rst | (state==NNRST), so the network is reset together with this block.
- `nn_data` is driven directly from the bitmap register. It is stable from START through NNRST because no transfers occur in those states.
- Reset state and values:
  - FSM in CAPTURE, counters 0, bitmap 0, `result` 0.
  - `nn_start` 0, `result_valid` 0, `busy` 0.
  - While `Rst` is high, `pix_ready` is 0 and `nn_rst` is 1.
- Reset mid-frame or mid-WAIT: abandon immediately, with no `result_valid` pulse. Any pending `nn_resp` is ignored.

## Timing

- Throughput: one pixel per cycle in CAPTURE. A frame is 784×SCALE² transfers.
- Last pixel transferred in cycle N:
  - Bitmap complete and state START at N+1, `nn_start` high in N+1.
  - WAIT from N+2.
- `nn_resp` first sampled high in cycle M (M ≥ N+2):
  - In M+1: `result` valid, `result_valid` high, `nn_rst` high.
  - In M+2: state CAPTURE, `pix_ready` high.
- `nn_resp` high during START is ignored; it is only sampled in WAIT.
- `pix_valid` outside CAPTURE is not consumed. Upstream must hold its data.

## Test plan

- **All-dark frame**, SCALE=2, 3136 pixels of value 0 back-to-back:
  - `nn_data`=0.
  - `nn_start` pulses exactly once, 1 cycle after the last transfer.
  - `busy`=1 from that cycle.
- **Single ink pixel**, SCALE=10, canvas x=25, y=13 set to 200:
  - Only bit 30 (cell row 1, col 2) is set.
  - The neighbouring pixel at x=30 lights only bit 31.
- **Threshold boundary**, SCALE=1, pixel 0 = 127 and pixel 1 = 128:
  - Bit 0 = 0, bit 1 = 1.
- **Mid-frame resync**, SCALE=1:
  - Send 100 ink pixels, then a `pix_sof` pixel with value 0, then 783 dark pixels.
  - `nn_data`=0, and `nn_start` fires after exactly 784 post-sof transfers.
- **Handshake**: raise `nn_resp` 5 cycles into WAIT with `nn_prediction`=7:
  - `result`=7 and a single-cycle `result_valid`.
  - `nn_rst` is one cycle, then `pix_ready`=1 the next cycle.
  - The next frame's first pixel clears the bitmap.
- **Reset mid-WAIT**: assert `Rst` one cycle while waiting, with `nn_resp`=1 the same cycle:
  - No `result_valid`, `result` is 0, `nn_rst` is 1 that cycle.
  - State returns to CAPTURE with `pix_ready`=1 after reset deasserts.
